// File: rtl/noc_pkt_traffic_gen.sv
// NoC packet traffic source driving the NSU ingress flit interface with programmed bursts.
// Optional macro NOC_GEN_PRBS_DATA_EN switches write data from counter pattern to 32-bit LFSR.
module noc_pkt_traffic_gen #(
  parameter int         DATA_WIDTH     = 128,
  parameter int         ID_WIDTH       = 4,
  parameter int         VIRTUAL_CH_NUM = 16,
  parameter int         AXI_ADDR_WIDTH = 32,
  parameter logic [2:0] TYPE_WRITE     = 3'b100,
  parameter logic [2:0] TYPE_RD_REQ    = 3'b010,
  parameter logic [3:0] HEAD_CODE_H    = 4'h5,
  parameter logic [3:0] HEAD_CODE_E    = 4'hA,
  parameter logic [3:0] TAIL_CODE_H    = 4'h0,
  parameter logic [3:0] TAIL_CODE_E    = 4'hF,
  parameter int         INIT_CYCLES    = 11,
  parameter int         GAP_CYCLES     = 2
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic                      ddr_init_done,
  input  logic                      start,
  input  logic                      cfg_wr,
  input  logic [ID_WIDTH-1:0]       cfg_src_id,
  input  logic [ID_WIDTH-1:0]       cfg_dst_id,
  input  logic [7:0]                cfg_len,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [VIRTUAL_CH_NUM-1:0] cfg_pkt_num,
  output logic [DATA_WIDTH:0]       noc2axi_data,
  output logic                      s_is_head,
  output logic                      s_is_tail,
  input  logic                      nsu_busy,
  output logic                      gen_busy,
  output logic                      gen_done
);

  localparam int FIELD_W     = 8 + 2*ID_WIDTH + 3 + VIRTUAL_CH_NUM + 8 + AXI_ADDR_WIDTH;
  localparam int PAD_W       = DATA_WIDTH - FIELD_W;
  localparam int BEAT_BYTES  = DATA_WIDTH / 8;
  localparam int REP         = DATA_WIDTH / 32;
  localparam int FIRST_ORDER = 1;

  typedef enum logic [2:0] {SETTLE, WAIT_INIT, IDLE, HEAD, DATA, TAIL, GAP, DONE} state_t;

  state_t                    state;
  logic [15:0]               settle_cnt;
  logic [7:0]                gap_cnt;
  logic [7:0]                beat;
  logic [VIRTUAL_CH_NUM-1:0] pkts_left;
  logic [VIRTUAL_CH_NUM-1:0] pack_order;
  logic [AXI_ADDR_WIDTH-1:0] pkt_addr;
  logic                      c_wr;
  logic [ID_WIDTH-1:0]       c_src, c_dst;
  logic [7:0]                c_len;
  logic [VIRTUAL_CH_NUM-1:0] c_num;

  logic [2:0]                pkt_type;
  logic [7:0]                last_beat;
  logic [AXI_ADDR_WIDTH-1:0] stride;
  logic [AXI_ADDR_WIDTH-1:0] re_pack;
  logic [31:0]               pat32;
  logic [DATA_WIDTH:0]       head_flit, data_flit, tail_flit;

`ifdef NOC_GEN_PRBS_DATA_EN
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  // Fibonacci form of x^32+x^22+x^2+x+1, new bit shifted in at the LSB
  assign lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign pat32     = lfsr;
`else
  assign pat32     = {16'(pack_order), 16'(beat)};
`endif

  assign pkt_type  = c_wr ? TYPE_WRITE : TYPE_RD_REQ;
  assign last_beat = c_wr ? c_len : 8'd0;
  assign stride    = AXI_ADDR_WIDTH'((32'(c_len) + 32'd1) * 32'(BEAT_BYTES));
  // Order restarts at FIRST_ORDER on every start, so the burst's first order is a constant
  assign re_pack   = AXI_ADDR_WIDTH'({16'(FIRST_ORDER), c_len});

  assign head_flit = {1'b1, HEAD_CODE_H, c_src, c_dst, pkt_type, pack_order, c_len,
                      pkt_addr, HEAD_CODE_E, {PAD_W{1'b0}}};
  assign tail_flit = {1'b1, TAIL_CODE_H, c_src, c_dst, pkt_type, c_num, c_len,
                      re_pack, TAIL_CODE_E, {PAD_W{1'b0}}};
  assign data_flit = c_wr ? {1'b1, {REP{pat32}}} : {1'b1, {DATA_WIDTH{1'b1}}};

  // State names the flit driven on the next advancing edge; advancing edges double as
  // the acceptance edge of the flit currently on the bus, so nsu_busy gates all of them.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state        <= SETTLE;
      settle_cnt   <= '0;
      gap_cnt      <= '0;
      beat         <= '0;
      pkts_left    <= '0;
      pack_order   <= '0;
      pkt_addr     <= '0;
      c_wr         <= 1'b0;
      c_src        <= '0;
      c_dst        <= '0;
      c_len        <= '0;
      c_num        <= '0;
      noc2axi_data <= '0;
      s_is_head    <= 1'b0;
      s_is_tail    <= 1'b0;
      gen_busy     <= 1'b0;
      gen_done     <= 1'b0;
`ifdef NOC_GEN_PRBS_DATA_EN
      lfsr         <= '0;
`endif
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == 16'(INIT_CYCLES - 1)) state <= WAIT_INIT;
          else settle_cnt <= settle_cnt + 16'd1;
        end
        WAIT_INIT: if (ddr_init_done) state <= IDLE;
        IDLE: begin
          gen_done <= 1'b0;
          if (start) begin
            c_wr       <= cfg_wr;
            c_src      <= cfg_src_id;
            c_dst      <= cfg_dst_id;
            c_len      <= cfg_len;
            c_num      <= cfg_pkt_num;
            pkts_left  <= (cfg_pkt_num == '0) ? VIRTUAL_CH_NUM'(1) : cfg_pkt_num;
            pack_order <= VIRTUAL_CH_NUM'(FIRST_ORDER);
            pkt_addr   <= cfg_addr;
            gen_busy   <= 1'b1;
            state      <= HEAD;
`ifdef NOC_GEN_PRBS_DATA_EN
            lfsr       <= 32'hACE1_0001;
`endif
          end
        end
        HEAD, DATA, TAIL, GAP, DONE: if (!nsu_busy) begin
          case (state)
            HEAD: begin
              noc2axi_data <= head_flit;
              s_is_head    <= 1'b1;
              s_is_tail    <= 1'b0;
              beat         <= '0;
              state        <= DATA;
            end
            DATA: begin
              noc2axi_data <= data_flit;
              s_is_head    <= 1'b0;
              beat         <= beat + 8'd1;
`ifdef NOC_GEN_PRBS_DATA_EN
              if (c_wr) lfsr <= lfsr_next;
`endif
              if (beat == last_beat) state <= TAIL;
            end
            TAIL: begin
              noc2axi_data <= tail_flit;
              s_is_tail    <= 1'b1;
              if (pkts_left > VIRTUAL_CH_NUM'(1)) begin
                pkts_left  <= pkts_left - VIRTUAL_CH_NUM'(1);
                pack_order <= pack_order + VIRTUAL_CH_NUM'(1);
                pkt_addr   <= pkt_addr + stride;
                gap_cnt    <= '0;
                state      <= (GAP_CYCLES == 0) ? HEAD : GAP;
              end else begin
                state <= DONE;
              end
            end
            GAP: begin
              noc2axi_data <= '0;
              s_is_head    <= 1'b0;
              s_is_tail    <= 1'b0;
              gap_cnt      <= gap_cnt + 8'd1;
              if (gap_cnt == 8'(GAP_CYCLES - 1)) state <= HEAD;
            end
            default: begin
              noc2axi_data <= '0;
              s_is_head    <= 1'b0;
              s_is_tail    <= 1'b0;
              gen_busy     <= 1'b0;
              gen_done     <= 1'b1;
              state        <= IDLE;
            end
          endcase
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_pkt_traffic_gen.sv
// Scoreboard bench for noc_pkt_traffic_gen: reference model pushes expected flits, monitor pops on acceptance.
module tb_noc_pkt_traffic_gen;

  localparam int GAP = 2;

  logic         noc_clk = 1'b0;
  logic         noc_rst, ddr_init_done, start, cfg_wr, nsu_busy;
  logic [3:0]   cfg_src_id, cfg_dst_id;
  logic [7:0]   cfg_len;
  logic [31:0]  cfg_addr;
  logic [15:0]  cfg_pkt_num;
  logic [128:0] noc2axi_data;
  logic         s_is_head, s_is_tail, gen_busy, gen_done;

  noc_pkt_traffic_gen dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst), .ddr_init_done(ddr_init_done), .start(start),
    .cfg_wr(cfg_wr), .cfg_src_id(cfg_src_id), .cfg_dst_id(cfg_dst_id), .cfg_len(cfg_len),
    .cfg_addr(cfg_addr), .cfg_pkt_num(cfg_pkt_num), .noc2axi_data(noc2axi_data),
    .s_is_head(s_is_head), .s_is_tail(s_is_tail), .nsu_busy(nsu_busy),
    .gen_busy(gen_busy), .gen_done(gen_done));

  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic [128:0] data;
    logic         head;
    logic         tail;
    logic         last;
    logic         gap_chk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, fails = 0;
  int   busy_mode = 0;
  int   gap_seen = 0;
  bit   done_pending = 0;
  bit   prev_held = 0;
  logic [128:0] prev_flit = '0;

  task automatic chk(string name, logic [128:0] act, logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  // Reference model: whole burst expanded from the packet rules with plain arithmetic
  task automatic push_burst(bit wr, logic [3:0] s, logic [3:0] d, logic [7:0] l,
                            logic [31:0] a, logic [15:0] n);
    int np = (n == 0) ? 1 : int'(n);
    logic [2:0]  ty = wr ? 3'b100 : 3'b010;
    logic [31:0] lf = 32'hACE1_0001;
    for (int p = 0; p < np; p++) begin
      logic [15:0] ord = 16'(p + 1);
      logic [31:0] pa  = a + 32'(p * (int'(l) + 1) * 16);
      exp_t e;
      e = '{{1'b1, 4'h5, s, d, ty, ord, l, pa, 4'hA, 53'd0}, 1'b1, 1'b0, 1'b0, p > 0};
      sb.push_back(e);
      if (wr) begin
        for (int k = 0; k <= int'(l); k++) begin
          logic [31:0] pat;
`ifdef NOC_GEN_PRBS_DATA_EN
          pat = lf;
          lf  = lfsr_step(lf);
`else
          pat = {ord, 16'(k)};
`endif
          e = '{{1'b1, pat, pat, pat, pat}, 1'b0, 1'b0, 1'b0, 1'b0};
          sb.push_back(e);
        end
      end else begin
        e = '{{1'b1, {128{1'b1}}}, 1'b0, 1'b0, 1'b0, 1'b0};
        sb.push_back(e);
      end
      e = '{{1'b1, 4'h0, s, d, ty, n, l, {8'd0, 16'd1, l}, 4'hF, 53'd0}, 1'b0, 1'b1,
            p == np - 1, 1'b0};
      sb.push_back(e);
    end
  endtask

  // Monitor: a flit counts as accepted when valid and not busy at the sampling point
  always @(negedge noc_clk) begin
    if (noc_rst) begin
      prev_held    = 0;
      done_pending = 0;
    end else begin
      if (prev_held) chk("hold_stable", noc2axi_data, prev_flit);
      chk("gen_done", gen_done, done_pending);
      done_pending = 0;
      prev_held = noc2axi_data[128] && nsu_busy;
      prev_flit = noc2axi_data;
      if (noc2axi_data[128] && !nsu_busy) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_flit: got %h expected none", noc2axi_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("flit", noc2axi_data, e.data);
          chk("head_tail_flags", {s_is_head, s_is_tail}, {e.head, e.tail});
          if (e.gap_chk) chk("gap_cycles", gap_seen, GAP);
          if (e.tail) gap_seen = 0;
          if (e.last) done_pending = 1;
        end
      end else if (!noc2axi_data[128] && !nsu_busy) begin
        gap_seen++;
      end
    end
  end

  initial begin : busy_drv
    nsu_busy = 1'b0;
    forever begin
      @(posedge noc_clk);
      #1;
      case (busy_mode)
        1: nsu_busy = ($urandom_range(0, 3) == 0);
        2: nsu_busy = 1'b1;
        default: nsu_busy = 1'b0;
      endcase
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge noc_clk);
    #1;
  endtask

  task automatic issue(bit wr, logic [3:0] s, logic [3:0] d, logic [7:0] l,
                       logic [31:0] a, logic [15:0] n, bit lat);
    @(posedge noc_clk);
    #1;
    cfg_wr = wr; cfg_src_id = s; cfg_dst_id = d; cfg_len = l; cfg_addr = a; cfg_pkt_num = n;
    start = 1'b1;
    push_burst(wr, s, d, l, a, n);
    @(posedge noc_clk);
    #1;
    start = 1'b0;
    cfg_len = $urandom; cfg_addr = $urandom; cfg_wr = $urandom;
    if (lat) begin
      @(negedge noc_clk);
      chk("latency_latch_cycle", {gen_busy, noc2axi_data[128]}, 2'b10);
      @(negedge noc_clk);
      chk("latency_first_head", {noc2axi_data[128], s_is_head}, 2'b11);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge noc_clk);
      if (!gen_busy && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL burst_timeout: got busy=%0d pending=%0d expected idle", gen_busy, sb.size());
      sb.delete();
    end
    cycles(3);
  endtask

  task automatic do_reset(bit ddr);
    @(posedge noc_clk);
    #1;
    noc_rst = 1'b1;
    ddr_init_done = ddr;
    cycles(3);
    noc_rst = 1'b0;
  endtask

  initial begin : stim
    noc_rst = 1'b1; ddr_init_done = 1'b1; start = 1'b0; cfg_wr = 1'b0;
    cfg_src_id = '0; cfg_dst_id = '0; cfg_len = '0; cfg_addr = '0; cfg_pkt_num = '0;
    cycles(3);
    @(negedge noc_clk);
    chk("reset_outputs", {noc2axi_data, s_is_head, s_is_tail, gen_busy, gen_done}, '0);
    @(posedge noc_clk);
    #1;
    noc_rst = 1'b0;
    cycles(20);

    // read request, single packet
    issue(1'b0, 4'h3, 4'hC, 8'h29, 32'h2000, 16'd1, 1'b1);
    wait_idle();

    // three write packets with a stray start mid-burst that must be ignored
    issue(1'b1, 4'h1, 4'h2, 8'd3, 32'h0, 16'd3, 1'b1);
    cycles(4);
    start = 1'b1; cfg_len = 8'd9;
    cycles(1);
    start = 1'b0;
    wait_idle();

    // sustained back-pressure in the data phase
    issue(1'b1, 4'h7, 4'h8, 8'd3, 32'h100, 16'd1, 1'b1);
    @(negedge noc_clk);
    busy_mode = 2;
    cycles(5);
    busy_mode = 0;
    wait_idle();

    // memory not ready: start must be ignored
    do_reset(1'b0);
    cycles(30);
    start = 1'b1; cfg_wr = 1'b1; cfg_pkt_num = 16'd2;
    cycles(1);
    start = 1'b0;
    cycles(19);
    @(negedge noc_clk);
    chk("no_init_idle", {gen_busy, noc2axi_data[128]}, 2'b00);
    ddr_init_done = 1'b1;
    cycles(5);

    // reset during the second data flit, then restart from order 1
    issue(1'b1, 4'h5, 4'h6, 8'd3, 32'h4000, 16'd2, 1'b0);
    for (int i = 0; i < 50 && !(noc2axi_data[128] && s_is_head); i++) @(negedge noc_clk);
    @(negedge noc_clk);
    @(negedge noc_clk);
    #1;
    noc_rst = 1'b1;
    #1;
    chk("async_reset_clear", {noc2axi_data, s_is_head, s_is_tail, gen_busy, gen_done}, '0);
    sb.delete();
    cycles(2);
    noc_rst = 1'b0;
    cycles(20);
    issue(1'b1, 4'h5, 4'h6, 8'd1, 32'h4000, 16'd2, 1'b1);
    wait_idle();

    // randomized bursts under random back-pressure
    busy_mode = 1;
    for (int t = 0; t < 10; t++) begin
      issue($urandom_range(0, 1), 4'($urandom), 4'($urandom), 8'($urandom_range(0, 7)),
            $urandom, 16'($urandom_range(1, 4)), 1'b0);
      wait_idle();
    end
    busy_mode = 0;
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
